// File: rtl/mem_responder_pkg.sv
// Shared defaults, FSM state encoding and the out-of-range read word for mem_responder.
package mem_responder_pkg;

    localparam int ADDR_WIDTH_DEF = 32;
    localparam int DATA_WIDTH_DEF = 32;

    // Returned for reads outside the array when bounds checking is built in.
    localparam logic [31:0] OOB_RD_WORD = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_GAP  = 2'd3
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Request side of the single-master memory bus; the shared Data bus is a separate inout net.
interface mem_responder_if
    import mem_responder_pkg::*;
#(
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) ();

    logic [ADDR_WIDTH-1:0] Addr;
    logic                  we;
    logic                  req_valid;
    logic                  data_valid;

    modport master (output Addr, output we, output req_valid, input data_valid);
    modport slave  (input Addr, input we, input req_valid, output data_valid);

endinterface

// File: rtl/mem_responder_ram.sv
// Single-port MEM_DEPTH x DATA_WIDTH array: write commits on the clock edge, read is combinational.
module mem_responder_ram #(
    parameter int MEM_DEPTH  = 64,
    parameter int DATA_WIDTH = 32
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [$clog2(MEM_DEPTH)-1:0] idx,
    input  logic [DATA_WIDTH-1:0]        wr_data,
    output logic [DATA_WIDTH-1:0]        rd_data
);

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // No reset: contents survive a reset of the responder.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[idx] <= wr_data;
        end
    end

    assign rd_data = mem[idx];

endmodule

// File: rtl/mem_responder.sv
// Memory-side bus responder: one request at a time, data_valid RESP_LATENCY cycles after acceptance,
// then one GAP cycle. Optional MEM_BOUNDS_CHECK_EN flags upper address bits as out-of-range.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int MEM_DEPTH    = 64,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
    parameter int RESP_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    mem_responder_if.slave        bus,
    inout  wire  [DATA_WIDTH-1:0] Data
);

    localparam int AW = $clog2(MEM_DEPTH);
    localparam int CW = $clog2(RESP_LATENCY + 1);
    localparam logic [CW-1:0] CNT_LOAD = CW'(RESP_LATENCY - 1);

    state_t                state;
    state_t                state_nxt;
    logic [CW-1:0]         cnt;
    logic [AW-1:0]         idx_q;
    logic                  we_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [DATA_WIDTH-1:0] ram_rdata;
    logic [DATA_WIDTH-1:0] rd_word;
    logic                  wr_allow;
    logic                  accept;
    logic                  data_valid;
    logic                  data_oe;
    logic                  ram_we;

    assign accept = (state == ST_IDLE) && bus.req_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= CNT_LOAD;
        end else if (state == ST_WAIT) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Request is captured once; bus inputs are ignored until the next IDLE.
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_q <= bus.Addr[AW+1:2];
            we_q  <= bus.we;
            if (bus.we) begin
                wdat_q <= Data;
            end
        end
    end

`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [DATA_WIDTH-1:0] OOB_WORD = DATA_WIDTH'(OOB_RD_WORD);

    logic oob_q;
    logic unused_addr_bits;

    always_ff @(posedge clk) begin
        if (accept) begin
            oob_q <= |bus.Addr[ADDR_WIDTH-1:AW+2];
        end
    end

    assign wr_allow         = ~oob_q;
    assign rd_word          = oob_q ? OOB_WORD : ram_rdata;
    assign unused_addr_bits = ^bus.Addr[1:0];
`else
    logic unused_addr_bits;

    // Upper address bits alias onto the array.
    assign wr_allow         = 1'b1;
    assign rd_word          = ram_rdata;
    assign unused_addr_bits = ^{bus.Addr[1:0], bus.Addr[ADDR_WIDTH-1:AW+2]};
`endif

    always_comb begin
        state_nxt  = state;
        data_valid = 1'b0;
        data_oe    = 1'b0;
        ram_we     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    state_nxt = (RESP_LATENCY == 1) ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt == CW'(1)) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                data_valid = 1'b1;
                data_oe    = ~we_q;
                ram_we     = we_q & wr_allow;
                state_nxt  = ST_GAP;
            end
            ST_GAP: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.data_valid = data_valid;
    assign Data           = data_oe ? rd_word : {DATA_WIDTH{1'bz}};

    mem_responder_ram #(
        .MEM_DEPTH  (MEM_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_ram (
        .clk     (clk),
        .wr_en   (ram_we),
        .idx     (idx_q),
        .wr_data (wdat_q),
        .rd_data (ram_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: latency-2 main instance plus latency-1 and latency-5 instances.
module tb_mem_responder;
    import mem_responder_pkg::*;

    localparam int LAT = 2;
`ifdef MEM_BOUNDS_CHECK_EN
    localparam logic [31:0] OOB_EXP = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] OOB_EXP = 32'h0000_0013;
`endif

    typedef struct {
        bit          rd;
        logic [31:0] dat;
        int          due;
    } exp_t;

    logic clk;
    logic reset;
    int   cyc       = 0;
    int   checks    = 0;
    int   passes    = 0;
    int   pulse_cnt = 0;
    int   oe_bad    = 0;
    exp_t exp_q[$];

    mem_responder_if #(.ADDR_WIDTH(32)) bus ();
    wire  [31:0] data_bus;
    logic        tb_oe;
    logic [31:0] tb_wdat;
    assign data_bus = tb_oe ? tb_wdat : 32'bz;

    mem_responder #(
        .MEM_DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_LATENCY(LAT)
    ) dut (
        .clk(clk), .reset(reset), .bus(bus), .Data(data_bus)
    );

    mem_responder_if #(.ADDR_WIDTH(32)) bus1 ();
    mem_responder_if #(.ADDR_WIDTH(32)) bus5 ();
    wire  [31:0] data1;
    wire  [31:0] data5;
    logic [31:0] aux_addr;
    logic [31:0] aux_wdat;
    logic        aux_we;
    logic        aux_req1;
    logic        aux_req5;

    assign bus1.Addr      = aux_addr;
    assign bus1.we        = aux_we;
    assign bus1.req_valid = aux_req1;
    assign bus5.Addr      = aux_addr;
    assign bus5.we        = aux_we;
    assign bus5.req_valid = aux_req5;
    assign data1 = (aux_req1 && aux_we) ? aux_wdat : 32'bz;
    assign data5 = (aux_req5 && aux_we) ? aux_wdat : 32'bz;

    mem_responder #(
        .MEM_DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_LATENCY(1)
    ) dut_lat1 (
        .clk(clk), .reset(reset), .bus(bus1), .Data(data1)
    );

    mem_responder #(
        .MEM_DEPTH(64), .DATA_WIDTH(32), .ADDR_WIDTH(32), .RESP_LATENCY(5)
    ) dut_lat5 (
        .clk(clk), .reset(reset), .bus(bus5), .Data(data5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: every data_valid pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (dut.data_oe && !bus.data_valid) oe_bad++;
        if (!reset && bus.data_valid) begin
            pulse_cnt++;
            if (exp_q.size() == 0) begin
                chk("spurious_pulse", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp_cycle", 32'(cyc), 32'(e.due));
                if (e.rd) chk("rd_data", data_bus, e.dat);
                else      chk("wr_bus_released", 32'(dut.data_oe), 32'd0);
            end
        end
    end

    task automatic wait_pulse(output bit seen);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = bus.data_valid;
        end
    endtask

    task automatic do_req(input bit w, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] exp_rd, input string name);
        exp_t e;
        bit   seen;
        @(negedge clk);
        bus.Addr = a; bus.we = w; bus.req_valid = 1'b1; tb_wdat = d; tb_oe = w;
        e.rd = !w; e.dat = exp_rd; e.due = cyc + LAT;
        exp_q.push_back(e);
        wait_pulse(seen);
        if (!seen) chk({name, "_timeout"}, 32'd0, 32'd1);
        bus.req_valid = 1'b0; tb_oe = 1'b0;
        @(negedge clk);
    endtask

    task automatic aux_txn(input bit w, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] exp_rd);
        int          k;
        int          lat1 = -1;
        int          lat5 = -1;
        logic [31:0] rd1  = '0;
        logic [31:0] rd5  = '0;
        @(negedge clk);
        aux_addr = a; aux_we = w; aux_wdat = d; aux_req1 = 1'b1; aux_req5 = 1'b1;
        k = cyc;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (aux_req1 && bus1.data_valid) begin lat1 = cyc - k; rd1 = data1; aux_req1 = 1'b0; end
            if (aux_req5 && bus5.data_valid) begin lat5 = cyc - k; rd5 = data5; aux_req5 = 1'b0; end
        end
        aux_req1 = 1'b0; aux_req5 = 1'b0;
        chk("lat1_cycles", 32'(lat1), 32'd1);
        chk("lat5_cycles", 32'(lat5), 32'd5);
        if (!w) begin
            chk("lat1_rd_data", rd1, exp_rd);
            chk("lat5_rd_data", rd5, exp_rd);
        end
    endtask

    initial begin
        exp_t e;
        bit   seen;
        int   p0;

        reset = 1'b1; tb_oe = 1'b0; tb_wdat = '0;
        bus.Addr = '0; bus.we = 1'b0; bus.req_valid = 1'b0;
        aux_addr = '0; aux_wdat = '0; aux_we = 1'b0; aux_req1 = 1'b0; aux_req5 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_data_valid", 32'(bus.data_valid), 32'd0);
        chk("rst_oe", 32'(dut.data_oe), 32'd0);
        chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            do_req(1'b1, 32'(i * 4), (i == 0) ? 32'h0000_0013 : 32'(32'h1000 + i), '0, "preload");
        end

        do_req(1'b0, 32'h0, '0, 32'h0000_0013, "rd_0x0");
        do_req(1'b1, 32'h10, 32'hCAFE_F00D, '0, "wr_0x10");
        do_req(1'b0, 32'h10, '0, 32'hCAFE_F00D, "rd_0x10");
        do_req(1'b0, 32'hC, '0, 32'h0000_1003, "rd_0xc");
        do_req(1'b0, 32'h14, '0, 32'h0000_1005, "rd_0x14");
        do_req(1'b0, 32'h3, '0, 32'h0000_0013, "rd_lowbits");

        // Back-to-back reads with req_valid never dropped between them.
        @(negedge clk);
        bus.Addr = 32'h4; bus.we = 1'b0; bus.req_valid = 1'b1;
        e.rd = 1'b1; e.dat = 32'h0000_1001; e.due = cyc + LAT;
        exp_q.push_back(e);
        p0 = pulse_cnt;
        wait_pulse(seen);
        if (!seen) chk("b2b_first_timeout", 32'd0, 32'd1);
        bus.Addr = 32'h8;
        e.rd = 1'b1; e.dat = 32'h0000_1002; e.due = cyc + LAT + 2;
        exp_q.push_back(e);
        wait_pulse(seen);
        if (!seen) chk("b2b_second_timeout", 32'd0, 32'd1);
        bus.req_valid = 1'b0;
        repeat (6) @(negedge clk);
        chk("b2b_pulse_count", 32'(pulse_cnt - p0), 32'd2);

        // Reset lands while a write is waiting out its latency.
        @(negedge clk);
        bus.Addr = 32'h20; bus.we = 1'b1; tb_wdat = 32'h1234_5678; tb_oe = 1'b1; bus.req_valid = 1'b1;
        p0 = pulse_cnt;
        @(negedge clk);
        chk("pre_rst_wait_state", 32'(dut.state), 32'(ST_WAIT));
        reset = 1'b1;
        @(negedge clk);
        chk("rst_mid_req_idle", 32'(dut.state), 32'(ST_IDLE));
        reset = 1'b0; bus.req_valid = 1'b0; tb_oe = 1'b0;
        repeat (6) @(negedge clk);
        chk("rst_mid_req_no_pulse", 32'(pulse_cnt - p0), 32'd0);
        do_req(1'b0, 32'h20, '0, 32'h0000_1008, "rd_0x20_after_rst");

        do_req(1'b0, 32'h100, '0, OOB_EXP, "rd_0x100");

        aux_txn(1'b1, 32'h8, 32'hA5A5_0001, '0);
        aux_txn(1'b0, 32'h8, '0, 32'hA5A5_0001);

        chk("bus_release", 32'(oe_bad), 32'd0);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion by time limit, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
